// File: rtl/instr_loader.sv
// Loads a program into instruction memory one field-level beat at a time, encoding each beat into
// a 32-bit RV32I word. Optional macro INSTR_LOADER_RANGE_CHECK_EN rejects immediates that would truncate.
module instr_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam int unsigned WORD_W = 32;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    localparam logic [2:0] T_LOAD   = 3'd0;
    localparam logic [2:0] T_STORE  = 3'd1;
    localparam logic [2:0] T_RTYPE  = 3'd2;
    localparam logic [2:0] T_ITYPE  = 3'd3;
    localparam logic [2:0] T_BRANCH = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_WORD   = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;

    logic [WORD_W-1:0]   enc_word_c;
    logic                enc_legal_c;
    logic                shift_f3_c;

    // Beat encoder: builds the RV32I word and flags beats that cannot be encoded.
    always_comb begin
        enc_word_c  = '0;
        enc_legal_c = 1'b1;
        shift_f3_c  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        case (in_type)
            T_LOAD: begin
                enc_word_c = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OP_LOAD};
            end
            T_STORE: begin
                enc_word_c = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OP_STORE};
            end
            T_RTYPE: begin
                enc_word_c = {1'b0, in_funct7, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
            end
            T_ITYPE: begin
                if (shift_f3_c) begin
                    enc_word_c = {1'b0, in_funct7, 5'b00000, in_imm[4:0], in_rs1, in_funct3,
                                  in_rd, OP_ITYPE};
                end else begin
                    enc_word_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
                end
            end
            T_BRANCH: begin
                enc_word_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], OP_BRANCH};
                if (!((in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b100))) begin
                    enc_legal_c = 1'b0;
                end
            end
            default: begin
                enc_legal_c = 1'b0;
            end
        endcase
`ifdef INSTR_LOADER_RANGE_CHECK_EN
        // Reject offsets that would silently lose bits when truncated into the word.
        if ((in_type == T_BRANCH) && in_imm[0]) begin
            enc_legal_c = 1'b0;
        end
        if (((in_type == T_LOAD) || (in_type == T_STORE) || (in_type == T_ITYPE)) &&
            (in_imm[12] != in_imm[11])) begin
            enc_legal_c = 1'b0;
        end
`endif
    end

`ifndef INSTR_LOADER_RANGE_CHECK_EN
    // Branch offsets are halfword-aligned; bit 0 is dropped by the encoding.
    logic unused_imm_c;
    assign unused_imm_c = in_imm[0];
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (enc_legal_c) begin
                        state_d = S_WRITE;
                        wdata_d = enc_word_c;
                        last_d  = in_last;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_q == ADDR_MAX) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LOAD;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        we_d    = (state_d == S_WRITE);
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        hold_d  = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_ERR);
    end

    // State and registered outputs; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign in_ready   = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a field-level RV32I encoding model.
module tb_instr_loader;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [2:0]    in_type;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic          in_funct7;
    logic [12:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_hold;

    instr_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_type    (in_type),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          typ;
        int          rd;
        int          rs1;
        int          rs2;
        int          f3;
        int          f7;
        int          imm;
        bit          last;
        bit          has_exp;
        logic [31:0] exp_word;
    } beat_t;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t sess[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int typ, input int rd, input int rs1, input int rs2,
                                 input int f3, input int f7, input int imm, input bit last,
                                 input bit has_exp, input logic [31:0] exp_word);
        beat_t b;
        b.typ = typ; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7;
        b.imm = imm; b.last = last; b.has_exp = has_exp; b.exp_word = exp_word;
        return b;
    endfunction

    // Reference encoder written as field arithmetic on integers.
    function automatic logic [31:0] ref_encode(input beat_t b, output bit legal);
        logic [31:0] u;
        logic [31:0] regs;
        logic [31:0] w;
        u     = 32'(b.imm) & 32'h1fff;
        regs  = (32'(b.rs2) << 20) | (32'(b.rs1) << 15);
        legal = 1'b1;
        w     = 32'h0;
        case (b.typ)
            0: w = ((u & 32'hfff) << 20) | (32'(b.rs1) << 15) | (32'd2 << 12) | (32'(b.rd) << 7) | 32'h03;
            1: w = (((u >> 5) & 32'h7f) << 25) | regs | (32'd2 << 12) | ((u & 32'h1f) << 7) | 32'h23;
            2: w = (32'(b.f7) << 30) | regs | (32'(b.f3) << 12) | (32'(b.rd) << 7) | 32'h33;
            3: begin
                if (b.f3 == 1 || b.f3 == 5)
                    w = (32'(b.f7) << 30) | ((u & 32'h1f) << 20) | (32'(b.rs1) << 15);
                else
                    w = ((u & 32'hfff) << 20) | (32'(b.rs1) << 15);
                w = w | (32'(b.f3) << 12) | (32'(b.rd) << 7) | 32'h13;
            end
            4: begin
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) | regs |
                    (32'(b.f3) << 12) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
                legal = (b.f3 == 0 || b.f3 == 1 || b.f3 == 4);
            end
            default: legal = 1'b0;
        endcase
`ifdef INSTR_LOADER_RANGE_CHECK_EN
        if (b.typ == 4 && (b.imm % 2) != 0) legal = 1'b0;
        if ((b.typ == 0 || b.typ == 1 || b.typ == 3) && (b.imm < -2048 || b.imm > 2047)) legal = 1'b0;
`endif
        return w;
    endfunction

    task automatic drive_beat(input beat_t b);
        in_type   = 3'(b.typ);
        in_rd     = 5'(b.rd);
        in_rs1    = 5'(b.rs1);
        in_rs2    = 5'(b.rs2);
        in_funct3 = 3'(b.f3);
        in_funct7 = 1'(b.f7);
        in_imm    = 13'(b.imm);
        in_last   = b.last;
        in_valid  = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_wdata"}, imem_wdata,      32'd0);
        check({tag, "_ready"}, 32'(in_ready),   32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
        check({tag, "_hold"},  32'(cpu_hold),   32'd0);
    endtask

    // Runs one load session from the global queue, predicting every write and the final status.
    task automatic run_session();
        int          m_addr;
        int          waited;
        bit          legal;
        logic [31:0] exp_w;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_addr",  32'(imem_addr), 32'd0);
        check("start_hold",  32'(cpu_hold), 32'd1);
        m_addr = 0;
        foreach (sess[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("load_start_addr",  32'(imem_addr), 32'(m_addr));
                check("load_start_ready", 32'(in_ready), 32'd1);
            end
            waited = 0;
            while (!in_ready && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                check("ready_timeout", 32'(in_ready), 32'd1);
                return;
            end
            drive_beat(sess[i]);
            @(negedge clk);
            in_valid = 1'b0;
            exp_w = ref_encode(sess[i], legal);
            if (sess[i].has_exp) exp_w = sess[i].exp_word;
            if (!legal) begin
                check("illegal_we",    32'(imem_we), 32'd0);
                check("illegal_err",   32'(err), 32'd1);
                check("illegal_ready", 32'(in_ready), 32'd0);
                check("illegal_hold",  32'(cpu_hold), 32'd1);
                return;
            end
            check("we",         32'(imem_we), 32'd1);
            check("addr",       32'(imem_addr), 32'(m_addr));
            check("wdata",      imem_wdata, exp_w);
            check("write_busy", 32'(busy), 32'd1);
            check("write_rdy",  32'(in_ready), 32'd0);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            check("we_drop",    32'(imem_we), 32'd0);
            check("wdata_hold", imem_wdata, exp_w);
            if (sess[i].last) begin
                check("done",      32'(done), 32'd1);
                check("done_hold", 32'(cpu_hold), 32'd0);
                check("done_busy", 32'(busy), 32'd0);
                return;
            end
            if (m_addr == int'(DEPTH) - 1) begin
                check("ovf_err",  32'(err), 32'd1);
                check("ovf_hold", 32'(cpu_hold), 32'd1);
                check("ovf_addr", 32'(imem_addr), 32'(m_addr));
                return;
            end
            m_addr++;
            check("next_addr",  32'(imem_addr), 32'(m_addr));
            check("next_ready", 32'(in_ready), 32'd1);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        b.typ      = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        b.rd       = int'($urandom_range(0, 31));
        b.rs1      = int'($urandom_range(0, 31));
        b.rs2      = int'($urandom_range(0, 31));
        b.f3       = int'($urandom_range(0, 7));
        b.f7       = int'($urandom_range(0, 1));
        b.imm      = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4095)) - 2048
                                                 : int'($urandom_range(0, 8191)) - 4096;
        b.last     = last;
        b.has_exp  = 1'b0;
        b.exp_word = 32'h0;
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_type = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = 1'b0; in_imm = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        sess = {mk(3, 1, 0, 0, 0, 0, 5, 1'b0, 1'b1, 32'h00500093),
                mk(2, 3, 1, 2, 0, 0, 0, 1'b1, 1'b0, 32'h0)};
        run_session();
        sess = {mk(2, 3, 1, 2, 0, 0, 0, 1'b0, 1'b1, 32'h002081B3),
                mk(2, 3, 1, 2, 0, 1, 0, 1'b1, 1'b1, 32'h402081B3)};
        run_session();
        sess = {mk(1, 0, 1, 2, 0, 0, 8, 1'b0, 1'b1, 32'h0020A423),
                mk(4, 0, 1, 2, 0, 0, -8, 1'b1, 1'b1, 32'hFE208CE3)};
        run_session();
        sess = {mk(6, 1, 1, 1, 0, 0, 0, 1'b1, 1'b0, 32'h0)};
        run_session();
        sess = {mk(4, 0, 1, 2, 2, 0, 8, 1'b1, 1'b0, 32'h0)};
        run_session();
        sess = {mk(4, 0, 1, 2, 0, 0, 3, 1'b1, 1'b0, 32'h0)};
        run_session();
        sess = {mk(3, 1, 0, 0, 0, 0, 1, 1'b0, 1'b0, 32'h0), mk(3, 2, 0, 0, 0, 0, 2, 1'b0, 1'b0, 32'h0),
                mk(3, 3, 0, 0, 0, 0, 3, 1'b0, 1'b0, 32'h0), mk(3, 4, 0, 0, 0, 0, 4, 1'b0, 1'b0, 32'h0)};
        run_session();

        // Reset while the write is on the port clears everything.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive_beat(mk(2, 5, 6, 7, 0, 0, 0, 1'b0, 1'b0, 32'h0));
        @(negedge clk); in_valid = 1'b0;
        check("pre_rst_we", 32'(imem_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_write");
        rst = 1'b0;

        // Reset coinciding with acceptance never produces a write.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive_beat(mk(2, 5, 6, 7, 0, 0, 0, 1'b0, 1'b0, 32'h0));
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        check_all_zero("rst_accept");
        @(negedge clk);
        check("idle_we", 32'(imem_we), 32'd0);

        for (int s = 0; s < 40; s++) begin
            len = int'($urandom_range(1, DEPTH));
            sess.delete();
            for (int k = 0; k < len; k++) begin
                sess.push_back(rand_beat((k == len - 1) && (len < int'(DEPTH) || $urandom_range(0, 1) == 1)));
            end
            run_session();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
